// File: rtl/fdtd_buf_wb_ctrl.sv
// ---------------------------------------------------------------------------
// fdtd_buf_wb_ctrl
//   Write-back engine for the FDTD update loop. A rising edge on one of the
//   calc controller's wrt_*_start levels queues a transfer; the engine then
//   walks the matching ram_buffer (Hy or Ez) word by word, sign-extends each
//   word to 32 bits and writes it to data memory over a req/gnt/rvalid port
//   with at most one transaction outstanding. A one-cycle wb_done_o marks the
//   end of every transfer.
//
// Ports
//   CLK, RST_N            clock, asynchronous active-low reset
//   wrt_*_start_i         start levels (Hy, Ez, source); rising edge = request
//   buffer_size_i         Hy/Ez entry count, clamped to BUFFER_SIZE
//   hy/ez_base_addr_i     byte base addresses of the arrays in data memory
//   rd_*_buf_en/addr_o    buffer read port (data returns one cycle later)
//   *_buf_rdata_i         buffer read data
//   data_*                core data port (req/gnt/rvalid, write-only use)
//   wb_busy_o             high whenever a transfer is active
//   wb_done_o             one-cycle pulse at the end of a transfer
//   wb_type_o             01 Hy, 10 Ez, 11 source, 00 none since reset
// ---------------------------------------------------------------------------
module fdtd_buf_wb_ctrl #(
  parameter int BUFFER_ADDR_WIDTH = 6,
  parameter int FDTD_DATA_WIDTH   = 16,
  parameter int BUFFER_SIZE       = 50,
  parameter int MEM_ADDR_WIDTH    = 32
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         wrt_Hy_start_i,
  input  logic                         wrt_Ez_start_i,
  input  logic                         wrt_src_start_i,
  input  logic [FDTD_DATA_WIDTH-1:0]   buffer_size_i,
  input  logic [MEM_ADDR_WIDTH-1:0]    hy_base_addr_i,
  input  logic [MEM_ADDR_WIDTH-1:0]    ez_base_addr_i,
  output logic                         rd_Hy_buf_en_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] rd_Hy_buf_addr_o,
  output logic                         rd_Ez_buf_en_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] rd_Ez_buf_addr_o,
  input  logic [FDTD_DATA_WIDTH-1:0]   Hy_buf_rdata_i,
  input  logic [FDTD_DATA_WIDTH-1:0]   Ez_buf_rdata_i,
  output logic                         data_req_o,
  input  logic                         data_gnt_i,
  input  logic                         data_rvalid_i,
  output logic [MEM_ADDR_WIDTH-1:0]    data_addr_o,
  output logic                         data_we_o,
  output logic [3:0]                   data_be_o,
  output logic [31:0]                  data_wdata_o,
  output logic                         wb_busy_o,
  output logic                         wb_done_o,
  output logic [1:0]                   wb_type_o
);

  // One extra bit so a count equal to the clamp limit is always representable.
  localparam int CNT_W = BUFFER_ADDR_WIDTH + 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_BUF   = 3'd1;
  localparam logic [2:0] S_LATCH    = 3'd2;
  localparam logic [2:0] S_REQ      = 3'd3;
  localparam logic [2:0] S_WAIT_RSP = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_HY   = 2'b01;
  localparam logic [1:0] T_EZ   = 2'b10;
  localparam logic [1:0] T_SRC  = 2'b11;

  function automatic logic signed [31:0] sext_word(input logic [FDTD_DATA_WIDTH-1:0] w);
    return {{(32-FDTD_DATA_WIDTH){w[FDTD_DATA_WIDTH-1]}}, w};
  endfunction

  logic [2:0]                   state_q;
  logic [BUFFER_ADDR_WIDTH-1:0] index_q;
  logic [CNT_W-1:0]             count_q;
  logic [1:0]                   type_q;
  logic                         prev_hy_q, prev_ez_q, prev_src_q;
  logic                         pend_hy_q, pend_ez_q, pend_src_q;
  logic signed [31:0]           wr_data_p1;
  logic [MEM_ADDR_WIDTH-1:0]    wr_addr_p1;

  logic                         edge_hy, edge_ez, edge_src;
  logic [CNT_W-1:0]             clamp_cnt;
  logic [1:0]                   launch_type;
  logic [CNT_W-1:0]             launch_cnt;
  logic                         last_word;
  logic [FDTD_DATA_WIDTH-1:0]   rdata_sel;
  logic [MEM_ADDR_WIDTH-1:0]    base_sel;

  assign edge_hy  = wrt_Hy_start_i  & ~prev_hy_q;
  assign edge_ez  = wrt_Ez_start_i  & ~prev_ez_q;
  assign edge_src = wrt_src_start_i & ~prev_src_q;

  assign clamp_cnt = (buffer_size_i > FDTD_DATA_WIDTH'(BUFFER_SIZE)) ?
                     CNT_W'(BUFFER_SIZE) : CNT_W'(buffer_size_i);

  // Launch arbitration: Hy before Ez before source, only from IDLE.
  always_comb begin
    launch_type = T_NONE;
    launch_cnt  = '0;
    if (state_q == S_IDLE) begin
      if (pend_hy_q) begin
        launch_type = T_HY;
        launch_cnt  = clamp_cnt;
      end else if (pend_ez_q) begin
        launch_type = T_EZ;
        launch_cnt  = clamp_cnt;
      end else if (pend_src_q) begin
        launch_type = T_SRC;
        launch_cnt  = CNT_W'(1);
      end
    end
  end

  assign last_word = ({1'b0, index_q} + CNT_W'(1)) == count_q;
  // The source transfer reads Ez entry 0 and writes to the Ez array.
  assign rdata_sel = (type_q == T_HY) ? Hy_buf_rdata_i : Ez_buf_rdata_i;
  assign base_sel  = (type_q == T_HY) ? hy_base_addr_i : ez_base_addr_i;

  // Edge detection and pending requests; a new edge wins over a same-cycle launch.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_hy_q  <= 1'b0;
      prev_ez_q  <= 1'b0;
      prev_src_q <= 1'b0;
      pend_hy_q  <= 1'b0;
      pend_ez_q  <= 1'b0;
      pend_src_q <= 1'b0;
    end else begin
      prev_hy_q  <= wrt_Hy_start_i;
      prev_ez_q  <= wrt_Ez_start_i;
      prev_src_q <= wrt_src_start_i;
      pend_hy_q  <= (pend_hy_q  & (launch_type != T_HY))  | edge_hy;
      pend_ez_q  <= (pend_ez_q  & (launch_type != T_EZ))  | edge_ez;
      pend_src_q <= (pend_src_q & (launch_type != T_SRC)) | edge_src;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      count_q    <= '0;
      type_q     <= T_NONE;
      wr_data_p1 <= '0;
      wr_addr_p1 <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (launch_type != T_NONE) begin
            type_q  <= launch_type;
            count_q <= launch_cnt;
            index_q <= '0;
            state_q <= (launch_cnt == '0) ? S_DONE : S_RD_BUF;
          end
        end
        // p0: buffer read issued, data returns during LATCH
        S_RD_BUF: state_q <= S_LATCH;
        // p1: capture buffer word and target address for the memory request
        S_LATCH: begin
          wr_data_p1 <= sext_word(rdata_sel);
          wr_addr_p1 <= base_sel + MEM_ADDR_WIDTH'({index_q, 2'b00});
          state_q    <= S_REQ;
        end
        S_REQ: begin
          if (data_gnt_i) state_q <= S_WAIT_RSP;
        end
        S_WAIT_RSP: begin
          if (data_rvalid_i) begin
            if (last_word) begin
              state_q <= S_DONE;
            end else begin
              index_q <= index_q + BUFFER_ADDR_WIDTH'(1);
              state_q <= S_RD_BUF;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the state register directly so reset drops them at once.
  assign rd_Hy_buf_en_o   = (state_q == S_RD_BUF) && (type_q == T_HY);
  assign rd_Ez_buf_en_o   = (state_q == S_RD_BUF) && ((type_q == T_EZ) || (type_q == T_SRC));
  assign rd_Hy_buf_addr_o = rd_Hy_buf_en_o ? index_q : '0;
  assign rd_Ez_buf_addr_o = rd_Ez_buf_en_o ? index_q : '0;

  assign data_req_o   = (state_q == S_REQ);
  assign data_we_o    = data_req_o;
  assign data_be_o    = data_req_o ? 4'hF : 4'h0;
  assign data_addr_o  = wr_addr_p1;
  assign data_wdata_o = wr_data_p1;

  assign wb_busy_o = (state_q != S_IDLE);
  assign wb_done_o = (state_q == S_DONE);
  assign wb_type_o = type_q;

endmodule

// File: tb/tb_fdtd_buf_wb_ctrl.sv
module tb_fdtd_buf_wb_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        wrt_Hy_start_i, wrt_Ez_start_i, wrt_src_start_i;
  logic [15:0] buffer_size_i;
  logic [31:0] hy_base_addr_i, ez_base_addr_i;
  logic        rd_Hy_buf_en_o, rd_Ez_buf_en_o;
  logic [5:0]  rd_Hy_buf_addr_o, rd_Ez_buf_addr_o;
  logic [15:0] Hy_buf_rdata_i, Ez_buf_rdata_i;
  logic        data_req_o, data_gnt_i, data_rvalid_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        wb_busy_o, wb_done_o;
  logic [1:0]  wb_type_o;

  always #5 CLK = ~CLK;

  fdtd_buf_wb_ctrl dut (
    .CLK(CLK), .RST_N(RST_N),
    .wrt_Hy_start_i(wrt_Hy_start_i), .wrt_Ez_start_i(wrt_Ez_start_i),
    .wrt_src_start_i(wrt_src_start_i), .buffer_size_i(buffer_size_i),
    .hy_base_addr_i(hy_base_addr_i), .ez_base_addr_i(ez_base_addr_i),
    .rd_Hy_buf_en_o(rd_Hy_buf_en_o), .rd_Hy_buf_addr_o(rd_Hy_buf_addr_o),
    .rd_Ez_buf_en_o(rd_Ez_buf_en_o), .rd_Ez_buf_addr_o(rd_Ez_buf_addr_o),
    .Hy_buf_rdata_i(Hy_buf_rdata_i), .Ez_buf_rdata_i(Ez_buf_rdata_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .wb_busy_o(wb_busy_o), .wb_done_o(wb_done_o),
    .wb_type_o(wb_type_o)
  );

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [1:0]  done_q[$];
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  logic [15:0] hy_mem [64];
  logic [15:0] ez_mem [64];

  int gnt_dly = 0;
  int rsp_dly = 0;
  bit stray_rv = 0;
  bit outstanding = 0;
  int req_wait = 0;
  int rsp_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Buffer RAMs: one-cycle read latency, filler value when not read.
  always @(posedge CLK) begin
    Hy_buf_rdata_i <= rd_Hy_buf_en_o ? hy_mem[rd_Hy_buf_addr_o] : 16'h5A5A;
    Ez_buf_rdata_i <= rd_Ez_buf_en_o ? ez_mem[rd_Ez_buf_addr_o] : 16'hA5A5;
  end

  // Expected transfer: words 0..min(size,50)-1 (source: Ez word 0 only),
  // each sign-extended, at base + 4*i.
  task automatic plan(input logic [1:0] t, input int n);
    int cnt;
    wr_t w;
    cnt = (t == 2'b11) ? 1 : ((n > 50) ? 50 : n);
    for (int i = 0; i < cnt; i++) begin
      logic [15:0] v;
      v = (t == 2'b01) ? hy_mem[i] : ez_mem[i];
      w.a = ((t == 2'b01) ? hy_base_addr_i : ez_base_addr_i) + 32'(4 * i);
      w.d = {{16{v[15]}}, v};
      exp_q.push_back(w);
    end
    done_q.push_back(t);
  endtask

  // Memory slave and per-cycle comparison against the expected queues.
  initial begin
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0;
    forever begin
      @(negedge CLK);
      data_gnt_i = 1'b0;
      data_rvalid_i = 1'b0;
      if (!RST_N) begin
        outstanding = 0;
        req_wait = 0;
      end else begin
        if (rd_Hy_buf_en_o || rd_Ez_buf_en_o)
          chk("rd_en_exclusive", 32'(rd_Hy_buf_en_o & rd_Ez_buf_en_o), 32'd0);
        if (data_req_o) begin
          chk("single_outstanding", 32'(outstanding), 32'd0);
          chk("we_be", 32'({data_we_o, data_be_o}), 32'h1F);
          chk("busy_during_req", 32'(wb_busy_o), 32'd1);
          if (exp_q.size() == 0) begin
            chk("unexpected_req", data_addr_o, 32'hFFFFFFFF);
          end else begin
            chk("wr_addr", data_addr_o, exp_q[0].a);
            chk("wr_data", data_wdata_o, exp_q[0].d);
          end
          if (req_wait >= gnt_dly) begin
            data_gnt_i = 1'b1;
            outstanding = 1;
            rsp_wait = rsp_dly;
            req_wait = 0;
            log_a.push_back(data_addr_o);
            log_d.push_back(data_wdata_o);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end else begin
            req_wait++;
            if (stray_rv) data_rvalid_i = 1'b1;
          end
        end else if (outstanding) begin
          chk("busy_during_wait", 32'(wb_busy_o), 32'd1);
          if (rsp_wait == 0) begin
            data_rvalid_i = 1'b1;
            outstanding = 0;
          end else begin
            rsp_wait--;
          end
        end
        if (wb_done_o) begin
          if (done_q.size() == 0) chk("unexpected_done", 32'(wb_type_o), 32'hFFFFFFFF);
          else chk("done_type", 32'(wb_type_o), 32'(done_q.pop_front()));
        end
      end
    end
  end

  task automatic wait_done(input int budget, output int lat);
    bit seen;
    seen = 0;
    lat = 0;
    @(posedge CLK);
    while (!seen && lat < budget) begin
      @(posedge CLK);
      lat++;
      #1;
      if (wb_done_o) seen = 1;
    end
    if (!seen) begin
      chk("done_timeout", 32'(lat), 32'(budget + 1));
    end else begin
      @(posedge CLK);
      #1;
      chk("done_one_cycle", 32'(wb_done_o), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=expired required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    RST_N = 1'b0;
    wrt_Hy_start_i = 0; wrt_Ez_start_i = 0; wrt_src_start_i = 0;
    buffer_size_i = 16'd4;
    hy_base_addr_i = 32'h1000;
    ez_base_addr_i = 32'h4000;
    for (int i = 0; i < 64; i++) begin
      hy_mem[i] = 16'(i * 16'h0101) ^ 16'h8001;
      ez_mem[i] = 16'(i * 16'h0305) ^ 16'h7F10;
    end
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_ctrl_outs", 32'({rd_Hy_buf_en_o, rd_Ez_buf_en_o, data_req_o, data_we_o,
                              data_be_o, wb_busy_o, wb_done_o, wb_type_o}), 32'd0);
    chk("rst_data_addr", data_addr_o, 32'd0);
    chk("rst_data_wdata", data_wdata_o, 32'd0);
    chk("rst_rd_addrs", 32'({rd_Hy_buf_addr_o, rd_Ez_buf_addr_o}), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Hy transfer, immediate gnt/rvalid
    hy_mem[0] = 16'h0001; hy_mem[1] = 16'h8000; hy_mem[2] = 16'h7FFF; hy_mem[3] = 16'h0010;
    log_a.delete(); log_d.delete();
    plan(2'b01, 4);
    @(negedge CLK);
    wrt_Hy_start_i = 1;
    wait_done(100, lat);
    chk("hy_done_latency", 32'(lat), 32'd17);
    chk("hy_nwrites", 32'(log_a.size()), 32'd4);
    if (log_a.size() == 4) begin
      chk("hy_w0_addr", log_a[0], 32'h1000);
      chk("hy_w0_data", log_d[0], 32'h00000001);
      chk("hy_w1_data", log_d[1], 32'hFFFF8000);
      chk("hy_w2_data", log_d[2], 32'h00007FFF);
      chk("hy_w3_addr", log_a[3], 32'h100C);
      chk("hy_w3_data", log_d[3], 32'h00000010);
    end
    repeat (3) @(negedge CLK);
    chk("type_hold_hy", 32'(wb_type_o), 32'd1);
    chk("idle_not_busy", 32'(wb_busy_o), 32'd0);
    wrt_Hy_start_i = 0;

    // Backpressure with stray rvalid while waiting for grant
    hy_mem[0] = 16'h1234; hy_mem[1] = 16'hFEDC; hy_mem[2] = 16'h0F0F; hy_mem[3] = 16'h8421;
    hy_base_addr_i = 32'h3000;
    gnt_dly = 3; rsp_dly = 2; stray_rv = 1;
    log_a.delete(); log_d.delete();
    plan(2'b01, 4);
    @(negedge CLK);
    wrt_Hy_start_i = 1;
    wait_done(300, lat);
    chk("bp_all_written", 32'(exp_q.size()), 32'd0);
    chk("bp_nwrites", 32'(log_a.size()), 32'd4);
    @(negedge CLK);
    wrt_Hy_start_i = 0;
    gnt_dly = 0; rsp_dly = 0; stray_rv = 0;

    // Clamp: 60 requested, 50 written
    for (int i = 0; i < 64; i++) hy_mem[i] = 16'(i * 16'h0407) ^ 16'hC003;
    hy_base_addr_i = 32'h2000;
    buffer_size_i = 16'd60;
    log_a.delete(); log_d.delete();
    plan(2'b01, 60);
    @(negedge CLK);
    wrt_Hy_start_i = 1;
    wait_done(400, lat);
    chk("clamp_nwrites", 32'(log_a.size()), 32'd50);
    if (log_a.size() > 0) chk("clamp_last_addr", log_a[log_a.size()-1], 32'h20C4);
    chk("clamp_all_written", 32'(exp_q.size()), 32'd0);
    @(negedge CLK);
    wrt_Hy_start_i = 0;

    // Zero count: done pulse, no memory access
    buffer_size_i = 16'd0;
    log_a.delete(); log_d.delete();
    plan(2'b01, 0);
    @(negedge CLK);
    wrt_Hy_start_i = 1;
    wait_done(20, lat);
    chk("zero_nwrites", 32'(log_a.size()), 32'd0);
    @(negedge CLK);
    wrt_Hy_start_i = 0;

    // Overlap: Ez running, Hy and src requested meanwhile
    hy_base_addr_i = 32'h1000;
    buffer_size_i = 16'd3;
    log_a.delete(); log_d.delete();
    plan(2'b10, 3);
    plan(2'b01, 3);
    plan(2'b11, 0);
    @(negedge CLK);
    wrt_Ez_start_i = 1;
    repeat (3) @(negedge CLK);
    wrt_Hy_start_i = 1;
    wrt_src_start_i = 1;
    wait_done(100, lat);
    wait_done(100, lat);
    wait_done(100, lat);
    chk("ovl_nwrites", 32'(log_a.size()), 32'd7);
    if (log_a.size() == 7) begin
      chk("ovl_src_addr", log_a[6], 32'h4000);
      chk("ovl_first_addr", log_a[0], 32'h4000);
      chk("ovl_hy_addr", log_a[3], 32'h1000);
    end
    chk("ovl_done_left", 32'(done_q.size()), 32'd0);
    chk("type_hold_src", 32'(wb_type_o), 32'd3);
    @(negedge CLK);
    wrt_Hy_start_i = 0; wrt_Ez_start_i = 0; wrt_src_start_i = 0;

    // Level start held 4 cycles: one transfer
    buffer_size_i = 16'd2;
    log_a.delete(); log_d.delete();
    plan(2'b01, 2);
    @(negedge CLK);
    wrt_Hy_start_i = 1;
    repeat (4) @(negedge CLK);
    wrt_Hy_start_i = 0;
    wait_done(100, lat);
    repeat (30) @(negedge CLK);
    chk("level_nwrites", 32'(log_a.size()), 32'd2);
    chk("level_done_left", 32'(done_q.size()), 32'd0);

    // Reset while request pending
    gnt_dly = 1000;
    buffer_size_i = 16'd4;
    plan(2'b01, 4);
    @(negedge CLK);
    wrt_Hy_start_i = 1;
    lat = 0;
    do begin
      @(negedge CLK);
      #1;
      lat++;
    end while (!data_req_o && lat < 50);
    chk("rst_reach_req", 32'(data_req_o), 32'd1);
    @(negedge CLK);
    wrt_Ez_start_i = 1;
    @(negedge CLK);
    wrt_Ez_start_i = 0;
    wrt_Hy_start_i = 0;
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_req_drop", 32'(data_req_o), 32'd0);
    chk("rst_busy_drop", 32'(wb_busy_o), 32'd0);
    chk("rst_no_done", 32'(wb_done_o), 32'd0);
    chk("rst_type_clear", 32'(wb_type_o), 32'd0);
    exp_q.delete();
    done_q.delete();
    gnt_dly = 0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    hy_base_addr_i = 32'h5000;
    buffer_size_i = 16'd2;
    log_a.delete(); log_d.delete();
    plan(2'b01, 2);
    @(negedge CLK);
    wrt_Hy_start_i = 1;
    wait_done(100, lat);
    repeat (30) @(negedge CLK);
    chk("post_rst_nwrites", 32'(log_a.size()), 32'd2);
    if (log_a.size() > 0) chk("post_rst_first_addr", log_a[0], 32'h5000);
    chk("post_rst_all_written", 32'(exp_q.size()), 32'd0);
    chk("post_rst_done_left", 32'(done_q.size()), 32'd0);
    wrt_Hy_start_i = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
